rgb_out_stage: RTL
==================

Name: rgb_out_stage

Overview:
- Parametrised successor to the fixed 24-bit RGB buffer strip.
- Takes packed per-channel digital colour codes from the controller and re-times them through a configurable register pipeline, so every DAC input changes on the same clock edge.
- Adds two controls:
  - synchronous blanking, which forces the outputs to zero;
  - a built-in DAC calibration ramp that sweeps all channels through every code.
- Sits between the controller and the per-channel DACs.

Parameters:
- BITS, 8: code width per channel; legal range 2..10.
- CHANNELS, 3: number of colour channels; legal range 1..4.
- STAGES, 1: pipeline register depth, din to dout; legal range 1..4.
- CAL_HOLD, 4: clock cycles each ramp code is held; legal range 1..256.

Ports:
- clk, input, 1: single design clock.
- reset, input, 1: synchronous, active-high reset.
- din, input, CHANNELS*BITS: packed codes. Channel 0 is in bits [BITS-1:0].
- blank, input, 1: when high, the sampled value is forced to all zeros.
- cal_start, input, 1: single-cycle request to start the calibration ramp.
- dout, output, CHANNELS*BITS: registered codes to the DACs.
- cal_busy, output, 1: high while the ramp is running.
- cal_done, output, 1: one-cycle pulse when the ramp completes.

Behaviour:
- All state is updated on the rising edge of clk. There is no combinational path from any input to any output.
- Reset:
  - dout, all pipeline stages, cal_busy and cal_done go to 0.
  - The FSM goes to IDLE; the ramp code and hold counter go to 0.
  - A reset mid-ramp aborts the ramp with no cal_done pulse.
- Pipeline:
  - The stage-1 input is the selected source: din in IDLE, or the ramp code replicated to all channels in RAMP.
  - If blank is high, the stage-1 input is forced to 0.
  - dout equals the stage-1 input sampled STAGES cycles earlier.
  - Blank therefore has the same latency as data.
- FSM states: IDLE, RAMP, DONE.
  - IDLE to RAMP: cal_start=1. Ramp code and hold counter are set to 0, and cal_busy goes high on the next cycle.
  - RAMP, per cycle:
    - The hold counter increments.
    - When it reaches CAL_HOLD-1, it wraps to 0 and the code increments.
    - When the code is 2^BITS-1 and the hold counter is at CAL_HOLD-1, the FSM moves to DONE.
    - The ramp presents each code for exactly CAL_HOLD cycles, so RAMP lasts 2^BITS*CAL_HOLD cycles.
  - DONE: cal_done=1 for exactly one cycle, cal_busy=0, then back to IDLE.
- cal_start while in RAMP or DONE is ignored; it does not restart the ramp.
- blank during RAMP forces zeros on dout but the ramp keeps counting (blank overrides ramp).
- Ramp code width is BITS with no overflow. The last code is all-ones; there is no wrap back to 0 inside RAMP.
- din changes during RAMP are discarded. On return to IDLE, dout shows din again after STAGES cycles.
- cal_busy and cal_done are registered and are never high in the same cycle.

Optional Feature:
- Macro: RGB_OUT_STAGE_CAL_EN.
- Defined: calibration FSM, ramp counter, cal_busy and cal_done are present as described above.
- Not defined:
  - The FSM and counters are not synthesised.
  - cal_start is ignored.
  - cal_busy and cal_done are tied to 0.
  - The stage-1 source is always din, with blanking still applied.
  - Port list is unchanged.

Test Plan (BITS=8, CHANNELS=3, STAGES=2, CAL_HOLD=4, macro defined unless stated):
1. Reset then stream: din=0x123456 in cycle N, 0xABCDEF in cycle N+1 -> dout=0x123456 at N+2 and 0xABCDEF at N+3; dout=0 during reset.
2. Blank: din held at 0xFFFFFF, blank high for cycles 10..12 only -> dout=0 in cycles 12..14 and 0xFFFFFF otherwise.
3. Calibration: cal_start pulse in cycle 0 ->
   - cal_busy high in cycles 1..1024;
   - dout=0x000000 for 4 cycles, then 0x010101 for 4 cycles, ... up to 0xFFFFFF;
   - cal_done pulses once in cycle 1025;
   - cal_start pulses in cycles 100 and 1025 have no effect.
4. Reset mid-ramp: assert reset in cycle 500 of the ramp -> cal_busy=0, dout=0 next cycle; no cal_done; a later cal_start restarts the ramp from code 0x00.
5. Blank during ramp: blank high in ramp cycles 200..203 -> dout=0 two cycles later; code sequence and total duration of 1024 cycles unchanged.
6. Macro undefined: cal_start pulse -> cal_busy and cal_done stay 0 and dout keeps tracking din with 2-cycle latency.

Source files
------------

// File: rtl/rgb_out_stage.sv
// rgb_out_stage: re-times packed per-channel DAC codes through a STAGES-deep
// register pipeline, with synchronous blanking and an optional DAC calibration ramp.
// Optional feature macro: RGB_OUT_STAGE_CAL_EN (calibration FSM, ramp counter,
// cal_busy and cal_done). When the macro is undefined, cal_start is ignored and the
// status outputs are tied low.
module rgb_out_stage #(
    parameter int unsigned BITS     = 8,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned STAGES   = 1,
    parameter int unsigned CAL_HOLD = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CHANNELS*BITS-1:0] din,
    input  logic                     blank,
    input  logic                     cal_start,
    output logic [CHANNELS*BITS-1:0] dout,
    output logic                     cal_busy,
    output logic                     cal_done
);

    localparam int unsigned W = CHANNELS * BITS;

    // Stage-1 input after source selection and blanking
    logic [W-1:0] src;
    logic [W-1:0] pipe [STAGES];

`ifdef RGB_OUT_STAGE_CAL_EN
    // Hold counter needs at least one bit even when each code is held a single cycle
    localparam int unsigned    HW        = (CAL_HOLD > 1) ? $clog2(CAL_HOLD) : 1;
    localparam logic [HW-1:0]  HOLD_LAST = HW'(CAL_HOLD - 1);
    localparam logic [BITS-1:0] CODE_LAST = '1;

    typedef enum logic [1:0] {StIdle, StRamp, StDone} state_e;

    state_e          state_q, state_d;
    logic [BITS-1:0] code_q, code_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; cal_start only matters in idle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cal_start) state_d = StRamp;
            StRamp:  if (code_q == CODE_LAST && hold_q == HOLD_LAST) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Status outputs decoded from the next state so the flops line up with the state
    always_comb begin
        busy_d = (state_d == StRamp);
        done_d = (state_d == StDone);
    end

    // Ramp code / hold counter next values; idle keeps both parked at zero
    always_comb begin
        code_d = code_q;
        hold_d = hold_q;
        if (state_q == StIdle) begin
            code_d = '0;
            hold_d = '0;
        end else if (state_q == StRamp) begin
            if (hold_q == HOLD_LAST) begin
                hold_d = '0;
                // Last code is all-ones; never wrap back to zero inside the ramp
                if (code_q != CODE_LAST) code_d = code_q + BITS'(1);
            end else begin
                hold_d = hold_q + HW'(1);
            end
        end
    end

    // Ramp counters and registered status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            code_q <= '0;
            hold_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            code_q <= code_d;
            hold_q <= hold_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign cal_busy = busy_q;
    assign cal_done = done_q;

    // Source select: ramp code replicated on every channel while ramping; blank wins
    always_comb begin
        src = din;
        if (state_q == StRamp) begin
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                src[ch*BITS +: BITS] = code_q;
            end
        end
        if (blank) src = '0;
    end
`else
    // Calibration absent: cal_start has no load
    logic unused_cal_start;
    assign unused_cal_start = cal_start;

    assign cal_busy = 1'b0;
    assign cal_done = 1'b0;

    // Source is always din, with blanking applied
    always_comb begin
        src = blank ? '0 : din;
    end
`endif

    // Output pipeline; every channel moves on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < STAGES; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= src;
            for (int unsigned i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[STAGES-1];

endmodule
